// File: rtl/dp_ram_writer_if.sv
// Stream-in / RAM port A bundle for dp_ram_writer; names are from the writer's side.
// master = stream source and RAM sink (bench side), slave = the writer.
interface dp_ram_writer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  i_start;
    logic                  i_in_valid;
    logic [DATA_WIDTH-1:0] i_in_data;
    logic                  o_in_ready;
    logic                  i_release;
    logic                  o_we_a;
    logic [ADDR_WIDTH-1:0] o_addr_a;
    logic [DATA_WIDTH-1:0] o_data_a;
    logic                  o_img_done;
    logic                  o_buf_full;

    modport master (
        output i_start, i_in_valid, i_in_data, i_release,
        input  o_in_ready, o_we_a, o_addr_a, o_data_a, o_img_done, o_buf_full
    );

    modport slave (
        input  i_start, i_in_valid, i_in_data, i_release,
        output o_in_ready, o_we_a, o_addr_a, o_data_a, o_img_done, o_buf_full
    );
endinterface

// File: rtl/dp_ram_writer.sv
// Fills RAM port A with a batch of images, each preceded by CHAN_GROUPS pad slots.
// Define DP_RAM_WR_PAD_EN to write zeros into the pad slots; otherwise they are skipped.
`ifndef CHANS_PER_MEM
`define CHANS_PER_MEM 16
`endif
`ifndef STREAM_WIDTH
`define STREAM_WIDTH 8
`endif
`ifndef In_rows
`define In_rows 2
`endif
`ifndef RAM_DEPTH_ROWS
`define RAM_DEPTH_ROWS 3
`endif
`ifndef BATCH_SIZE
`define BATCH_SIZE 2
`endif

module dp_ram_writer #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int CHAN_GROUPS = `CHANS_PER_MEM / `STREAM_WIDTH,
    parameter int IN_ROWS     = `In_rows,
    parameter int ROW_DEPTH   = `RAM_DEPTH_ROWS,
    parameter int BATCH       = `BATCH_SIZE
) (
    input  logic           i_clk,
    input  logic           i_rst,
    dp_ram_writer_if.slave bus
);
    localparam int IMG_BEATS   = IN_ROWS * ROW_DEPTH * CHAN_GROUPS;
    localparam int IMG_SPAN    = IMG_BEATS + CHAN_GROUPS;
    localparam int TOTAL_SPACE = IMG_SPAN * BATCH;
    localparam int GW = (CHAN_GROUPS > 1) ? $clog2(CHAN_GROUPS) : 1;
    localparam int CW = (ROW_DEPTH > 1)   ? $clog2(ROW_DEPTH)   : 1;
    localparam int RW = (IN_ROWS > 1)     ? $clog2(IN_ROWS)     : 1;
    localparam int BW = (BATCH > 1)       ? $clog2(BATCH)       : 1;

    generate
        if (longint'(TOTAL_SPACE) > (longint'(1) << ADDR_WIDTH)) begin : g_space_check
            $error("dp_ram_writer: batch of images does not fit in the RAM address range");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_PAD, S_FILL, S_FULL} state_t;

    state_t                r_state, w_state_next;
    logic [ADDR_WIDTH-1:0] r_ptr,   w_ptr_next;
    logic [GW-1:0]         r_pad,   w_pad_next;
    logic [GW-1:0]         r_grp,   w_grp_next;
    logic [CW-1:0]         r_col,   w_col_next;
    logic [RW-1:0]         r_row,   w_row_next;
    logic [BW-1:0]         r_img,   w_img_next;
    logic                  r_we,    w_we_next;
    logic [ADDR_WIDTH-1:0] r_addr,  w_addr_next;
    logic [DATA_WIDTH-1:0] r_data,  w_data_next;
    logic                  r_done,  w_done_next;
    logic                  w_last_beat;

    assign w_last_beat = (r_grp == GW'(CHAN_GROUPS - 1)) &&
                         (r_col == CW'(ROW_DEPTH - 1)) &&
                         (r_row == RW'(IN_ROWS - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_pad   <= '0;
            r_grp   <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_img   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            r_pad   <= w_pad_next;
            r_grp   <= w_grp_next;
            r_col   <= w_col_next;
            r_row   <= w_row_next;
            r_img   <= w_img_next;
            r_we    <= w_we_next;
            r_addr  <= w_addr_next;
            r_data  <= w_data_next;
            r_done  <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_pad_next   = r_pad;
        w_grp_next   = r_grp;
        w_col_next   = r_col;
        w_row_next   = r_row;
        w_img_next   = r_img;
        w_we_next    = 1'b0;
        w_addr_next  = r_addr;
        w_data_next  = r_data;
        w_done_next  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    w_state_next = S_PAD;
                    w_ptr_next   = '0;
                    w_pad_next   = '0;
                    w_grp_next   = '0;
                    w_col_next   = '0;
                    w_row_next   = '0;
                    w_img_next   = '0;
                end
            end
            S_PAD: begin
                // Pad slots keep their addresses even when not written, so the map is build-independent.
`ifdef DP_RAM_WR_PAD_EN
                w_we_next   = 1'b1;
                w_data_next = '0;
`endif
                w_addr_next = r_ptr;
                w_ptr_next  = r_ptr + 1'b1;
                if (r_pad == GW'(CHAN_GROUPS - 1)) begin
                    w_pad_next   = '0;
                    w_state_next = S_FILL;
                end else begin
                    w_pad_next = r_pad + 1'b1;
                end
            end
            S_FILL: begin
                if (bus.i_in_valid) begin
                    w_we_next   = 1'b1;
                    w_addr_next = r_ptr;
                    w_data_next = bus.i_in_data;
                    w_ptr_next  = r_ptr + 1'b1;
                    if (r_grp == GW'(CHAN_GROUPS - 1)) begin
                        w_grp_next = '0;
                        if (r_col == CW'(ROW_DEPTH - 1)) begin
                            w_col_next = '0;
                            w_row_next = (r_row == RW'(IN_ROWS - 1)) ? '0 : r_row + 1'b1;
                        end else begin
                            w_col_next = r_col + 1'b1;
                        end
                    end else begin
                        w_grp_next = r_grp + 1'b1;
                    end
                    if (w_last_beat) begin
                        w_done_next = 1'b1;
                        if (r_img == BW'(BATCH - 1)) begin
                            w_state_next = S_FULL;
                        end else begin
                            w_img_next   = r_img + 1'b1;
                            w_state_next = S_PAD;
                        end
                    end
                end
            end
            S_FULL: begin
                if (bus.i_release) begin
                    w_state_next = S_IDLE;
                    w_ptr_next   = '0;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign bus.o_in_ready = (r_state == S_FILL);
    assign bus.o_buf_full = (r_state == S_FULL);
    assign bus.o_we_a     = r_we;
    assign bus.o_addr_a   = r_addr;
    assign bus.o_data_a   = r_data;
    assign bus.o_img_done = r_done;
endmodule

// File: doc/dp_ram_writer.md
DP_RAM_WRITER -- requirements
Module: dp_ram_writer

Interface
REQ-001 Parameter DATA_WIDTH, default 8: stream word and RAM data width.
REQ-002 Parameter ADDR_WIDTH, default 8: RAM address width.
REQ-003 Parameter CHAN_GROUPS, default `chans_per_mem/`stream_width: words per pixel.
REQ-004 Parameter IN_ROWS, default `In_rows: rows per image.
REQ-005 Parameter ROW_DEPTH, default `RAM_DEPTH_ROWS: pixels per row.
REQ-006 Parameter BATCH, default `batch_size: images per buffer fill.
REQ-007 Derived: IMG_BEATS = IN_ROWS*ROW_DEPTH*CHAN_GROUPS; IMG_SPAN = IMG_BEATS+CHAN_GROUPS; TOTAL_SPACE = IMG_SPAN*BATCH.
REQ-008 clk  in  1  single clock; all logic on posedge.
REQ-009 rst  in  1  reset, synchronous, active-low.
REQ-010 start  in  1  one-cycle request to begin a buffer fill.
REQ-011 in_valid  in  1  upstream word valid.
REQ-012 in_data  in  DATA_WIDTH  upstream word.
REQ-013 in_ready  out  1  writer accepts a word this cycle.
REQ-014 release  in  1  downstream reader has consumed the buffer.
REQ-015 we_a  out  1  RAM port A write enable.
REQ-016 addr_a  out  ADDR_WIDTH  RAM port A address.
REQ-017 data_a  out  DATA_WIDTH  RAM port A write data.
REQ-018 img_done  out  1  one-cycle pulse after the last beat of each image is written.
REQ-019 buf_full  out  1  whole batch written; buffer owned by reader.

Function
REQ-020 FSM states IDLE, PAD, FILL, FULL; in_ready SHALL be 1 only in FILL.
REQ-021 IDLE: start=1 -> PAD, image index 0, write pointer 0; start ignored in every other state.
REQ-022 PAD: SHALL write CHAN_GROUPS zero words at consecutive addresses, one per cycle, then -> FILL.
REQ-023 FILL: each cycle with in_valid&in_ready SHALL produce we_a=1, addr_a=pointer, data_a=in_data on the next cycle; pointer +1; no accepted beat -> we_a=0 next cycle.
REQ-024 Counters group (0..CHAN_GROUPS-1), column (0..ROW_DEPTH-1), row (0..IN_ROWS-1) SHALL advance on each accepted beat, each wrapping to 0 and carrying to the next.
REQ-025 Beat accepted with group, column and row all at their maximums: img_done pulses on the cycle its write is presented; -> PAD if image index < BATCH-1 (index +1), else -> FULL.
REQ-026 FULL: buf_full=1, we_a=0; release=1 -> IDLE, pointer 0, buf_full=0 next cycle; release outside FULL ignored.
REQ-027 Image b SHALL occupy addresses b*IMG_SPAN .. b*IMG_SPAN+IMG_SPAN-1, pad words first; addr_a SHALL never exceed TOTAL_SPACE-1.
REQ-028 Elaboration SHALL fail if TOTAL_SPACE > 2**ADDR_WIDTH.
REQ-029 start and release asserted together: FSM state decides; only one acts.

Reset
REQ-030 rst=0 at a clock edge -> IDLE; in_ready, we_a, addr_a, data_a, img_done, buf_full all 0; counters, pointer and image index 0.
REQ-031 Reset mid-PAD or mid-FILL SHALL drop any pending write (we_a=0 the next cycle); no partial-image recovery.

Configuration
REQ-032 Macro DP_RAM_WR_PAD_EN defined: PAD state writes zero words per REQ-022.
REQ-033 Macro undefined: PAD state still lasts CHAN_GROUPS cycles and advances the pointer, but we_a=0 throughout; the address map of REQ-027 is unchanged.

Verification (CHAN_GROUPS=2, IN_ROWS=2, ROW_DEPTH=3, BATCH=2, DATA_WIDTH=8, ADDR_WIDTH=8)
REQ-034 Reset, start, continuous in_valid with data 1..24 -> zero writes at addresses 0,1 and 14,15; data 1..12 at 2..13; 13..24 at 16..27; img_done pulses twice; buf_full=1.
REQ-035 in_valid toggling every other cycle -> same RAM contents as REQ-034; we_a is never 1 without a preceding accepted beat.
REQ-036 In FULL with in_valid=1 held for 10 cycles -> in_ready=0, no writes; release -> IDLE next cycle, buf_full=0.
REQ-037 start in FILL, release in FILL -> both ignored; fill completes as in REQ-034.
REQ-038 rst=0 after 5 accepted beats -> next cycle all outputs 0; new start rewrites from address 0.
REQ-039 Macro undefined, same stimulus as REQ-034 -> addresses 0,1,14,15 never written; data addresses identical.
